fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the RV32I five-stage pipeline. Holds the program counter and computes the next PC from sequential, stall and redirect inputs. Drives the address of the combinational instruction memory and captures the returned word into the IF/ID pipeline register. Sits between the hazard/branch logic (EX stage) and the decode stage; its registered outputs feed ID directly.

## Interface
- RESET_PC, 32'h0000_0000: byte address fetched first after reset.
- NOP_INSTR, 32'h0000_0013: bubble encoding (`addi x0,x0,0`) loaded into IF/ID on flush or redirect.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- stall  in  1  hazard unit: hold PC and IF/ID this cycle.
- flush  in  1  replace the IF/ID contents with a bubble at the next edge.
- redirect  in  1  taken branch or jump resolved in EX.
- redirect_target  in  32  byte address of the branch or jump target.
- instruction  in  32  word returned by instruction memory for imem_addr, valid in the same cycle.
- imem_addr  out  32  word index to instruction memory, equal to {2'b00, pc[31:2]}.
- pc  out  32  current fetch PC, byte address.
- ifid_instr  out  32  IF/ID instruction.
- ifid_pc  out  32  IF/ID PC of that instruction.
- ifid_pc4  out  32  IF/ID value of ifid_pc + 4.
- ifid_valid  out  1  IF/ID holds a real (non-bubble) instruction.
- misalign  out  1  registered 1-cycle pulse: accepted redirect_target had bits [1:0] != 0.
- fetch_count  out  32  count of valid instructions latched into IF/ID.

## Operation
- Per-edge priority: rst > redirect > stall > advance.
- **redirect = 1**
  - pc <= {redirect_target[31:2], 2'b00}.
  - IF/ID <= bubble (ifid_instr = NOP_INSTR, ifid_valid = 0, ifid_pc/ifid_pc4 = 0).
  - misalign <= |redirect_target[1:0].
  - Overrides a simultaneous stall and flush.
- **stall = 1, redirect = 0**
  - pc is held.
  - If flush = 1: IF/ID <= bubble.
  - Else: IF/ID is held.
- **advance (stall = 0, redirect = 0)**
  - pc <= pc + 4. Wraps modulo 2^32; 32'hFFFF_FFFC goes to 0.
  - If flush = 1: IF/ID <= bubble.
  - Else: ifid_instr <= instruction, ifid_pc <= pc, ifid_pc4 <= pc + 4, ifid_valid <= 1.
- fetch_count increments by 1 exactly when a real instruction is latched (advance with flush = 0). It wraps at 2^32.
- misalign is 0 on every edge with no redirect.
- The block never consumes instruction while rst is high, so an undriven or Z memory output during reset has no effect.

## Timing
- Reset values, applied immediately on rst rising:
  - pc = RESET_PC; imem_addr = RESET_PC >> 2.
  - ifid_instr = NOP_INSTR; ifid_pc = 0; ifid_pc4 = 0; ifid_valid = 0.
  - misalign = 0; fetch_count = 0.
- First edge after rst deasserts: IF/ID captures the word at RESET_PC.
- imem_addr and pc change only on clock edges (or asynchronously on reset). Memory is combinational, so the fetch-to-IF/ID latency is 1 cycle.
- Redirect asserted in cycle n:
  - Cycle n+1: pc = target, IF/ID holds a bubble.
  - Cycle n+2: IF/ID holds the target instruction.
  - Branch penalty is 1 bubble from this stage.
- Stall held for k cycles: pc and IF/ID are frozen for k edges, and fetch resumes on the first edge with stall = 0.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values. Pending redirect information is discarded.

## Structure
- Shared package riscv_pkg holds:
  - XLEN = 32.
  - NOP_INSTR constant.
  - Default RESET_PC.
  - Typedef for the IF/ID record: instr, pc, pc4, valid.
- Sub-module pc_gen holds the PC register, the next-PC mux (pc + 4 / aligned target / hold) and misalign generation.
- The IF/ID register and fetch_count live in fetch_stage.

## Test plan
- Reset then 4 free-running cycles, with memory words 0..3 = A,B,C,D: ifid_instr goes A,B,C,D; ifid_pc goes 0,4,8,12; fetch_count = 4; ifid_valid = 1 from the first edge.
- Stall for 3 cycles while pc = 8: pc stays 8, IF/ID keeps B, fetch_count stays constant; next free edge latches C.
- Redirect to 32'h40 in cycle n: pc = 0x40, ifid_instr = 0x13, ifid_valid = 0 at n+1; word 16 appears in IF/ID at n+2, with ifid_pc4 = 0x44.
- Redirect to 32'h42 together with stall = 1: pc = 0x40, misalign pulses for exactly 1 cycle, IF/ID is a bubble.
- Flush without stall at pc = 4: IF/ID becomes a bubble, pc goes to 8, fetch_count does not increment.
- Assert rst asynchronously mid-cycle with pc = 0x40: pc = RESET_PC and ifid_valid = 0 before the next edge; pc wraps from 0xFFFF_FFFC to 0 on advance.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: machine width, bubble encoding and the
// IF/ID pipeline record.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic            valid;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{
        instr: NOP_INSTR,
        pc:    {XLEN{1'b0}},
        pc4:   {XLEN{1'b0}},
        valid: 1'b0
    };

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_gen.sv
// Program counter register with next-PC selection (redirect / hold / +4)
// and a registered pulse flagging a misaligned redirect target.
module pc_gen
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misalign
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_next;

    assign pc_plus4 = pc_q + XLEN'(4);

    always_comb begin
        pc_next = pc_plus4;
        if (redirect) begin
            pc_next = align_word(redirect_target);
        end else if (stall) begin
            pc_next = pc_q;
        end
    end

    // The low target bits are dropped from the PC but still reported.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            misalign <= 1'b0;
        end else begin
            pc_q     <= pc_next;
            misalign <= redirect & (|redirect_target[1:0]);
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: drives the combinational instruction memory and
// captures the returned word into the IF/ID register.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    input  logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] imem_addr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] ifid_instr,
    output logic [XLEN-1:0] ifid_pc,
    output logic [XLEN-1:0] ifid_pc4,
    output logic            ifid_valid,
    output logic            misalign,
    output logic [XLEN-1:0] fetch_count
);

    logic [XLEN-1:0] pc_plus4;
    ifid_t           ifid_q;
    ifid_t           ifid_next;
    logic [XLEN-1:0] count_q;
    logic            latch_instr;

    pc_gen #(
        .RESET_PC(RESET_PC)
    ) u_pc_gen (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_target(redirect_target),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .misalign       (misalign)
    );

    assign imem_addr   = {2'b00, pc[XLEN-1:2]};
    assign latch_instr = !redirect && !stall && !flush;

    // Redirect beats stall; flush bubbles IF/ID whether or not stalled.
    always_comb begin
        ifid_next = ifid_q;
        if (redirect || flush) begin
            ifid_next = IFID_BUBBLE;
        end else if (!stall) begin
            ifid_next = '{instr: instruction, pc: pc, pc4: pc_plus4, valid: 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_q  <= IFID_BUBBLE;
            count_q <= '0;
        end else begin
            ifid_q <= ifid_next;
            if (latch_instr) begin
                count_q <= count_q + XLEN'(1);
            end
        end
    end

    assign ifid_instr  = ifid_q.instr;
    assign ifid_pc     = ifid_q.pc;
    assign ifid_pc4    = ifid_q.pc4;
    assign ifid_valid  = ifid_q.valid;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a reference model pushes expected post-edge state
// into a scoreboard; directed scenarios add their own targeted checks.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic [31:0] instruction;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        misalign;
    logic [31:0] fetch_count;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .redirect       (redirect),
        .redirect_target(redirect_target),
        .instruction    (instruction),
        .imem_addr      (imem_addr),
        .pc             (pc),
        .ifid_instr     (ifid_instr),
        .ifid_pc        (ifid_pc),
        .ifid_pc4       (ifid_pc4),
        .ifid_valid     (ifid_valid),
        .misalign       (misalign),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] idx);
        return 32'hA5A5_0000 | {16'h0000, idx[15:0]};
    endfunction

    assign instruction = mem_word(imem_addr);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] ipc;
        logic [31:0] ipc4;
        logic [31:0] cnt;
        logic        valid;
        logic        mis;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, m_cnt;
    logic        m_valid, m_mis;

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0000_0013; m_ipc = 32'h0; m_ipc4 = 32'h0;
        m_valid = 1'b0; m_mis = 1'b0; m_cnt = 32'h0;
    endtask

    task automatic model_bubble();
        m_instr = 32'h0000_0013; m_ipc = 32'h0; m_ipc4 = 32'h0; m_valid = 1'b0;
    endtask

    // Drive one cycle, predict post-edge state, return at posedge+1.
    task automatic cycle(input logic s, input logic f, input logic r, input logic [31:0] t);
        exp_t e;
        stall = s; flush = f; redirect = r; redirect_target = t;
        if (r) begin
            model_bubble();
            m_mis = |t[1:0];
            m_pc  = t & 32'hFFFF_FFFC;
        end else begin
            m_mis = 1'b0;
            if (f) begin
                model_bubble();
            end else if (!s) begin
                m_instr = mem_word(m_pc >> 2);
                m_ipc   = m_pc;
                m_ipc4  = m_pc + 32'd4;
                m_valid = 1'b1;
                m_cnt   = m_cnt + 32'd1;
            end
            if (!s) m_pc = m_pc + 32'd4;
        end
        e.pc = m_pc; e.instr = m_instr; e.ipc = m_ipc; e.ipc4 = m_ipc4;
        e.cnt = m_cnt; e.valid = m_valid; e.mis = m_mis; e.due = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        #2;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            nvec += 7;
            if (pc !== mon_e.pc) begin nerr++; $display("FAIL sb_pc cyc=%0d: got %h want %h", cyc, pc, mon_e.pc); end
            if (imem_addr !== (mon_e.pc >> 2)) begin nerr++; $display("FAIL sb_imem_addr cyc=%0d: got %h want %h", cyc, imem_addr, mon_e.pc >> 2); end
            if (ifid_instr !== mon_e.instr) begin nerr++; $display("FAIL sb_ifid_instr cyc=%0d: got %h want %h", cyc, ifid_instr, mon_e.instr); end
            if (ifid_pc !== mon_e.ipc) begin nerr++; $display("FAIL sb_ifid_pc cyc=%0d: got %h want %h", cyc, ifid_pc, mon_e.ipc); end
            if (ifid_pc4 !== mon_e.ipc4) begin nerr++; $display("FAIL sb_ifid_pc4 cyc=%0d: got %h want %h", cyc, ifid_pc4, mon_e.ipc4); end
            if ({ifid_valid, misalign} !== {mon_e.valid, mon_e.mis}) begin nerr++; $display("FAIL sb_valid_misalign cyc=%0d: got %b%b want %b%b", cyc, ifid_valid, misalign, mon_e.valid, mon_e.mis); end
            if (fetch_count !== mon_e.cnt) begin nerr++; $display("FAIL sb_fetch_count cyc=%0d: got %0d want %0d", cyc, fetch_count, mon_e.cnt); end
        end
    end

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        nvec++;
        if ({pc, imem_addr, ifid_instr, ifid_pc, ifid_pc4, ifid_valid, misalign, fetch_count} !==
            {32'h0, 32'h0, 32'h0000_0013, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0}) begin
            nerr++;
            $display("FAIL reset_values: got pc=%h addr=%h instr=%h ipc=%h ipc4=%h v=%b mis=%b cnt=%0d want 0/0/00000013/0/0/0/0/0",
                     pc, imem_addr, ifid_instr, ifid_pc, ifid_pc4, ifid_valid, misalign, fetch_count);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_free_run();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0);
            nvec++;
            if (ifid_instr !== (32'hA5A5_0000 | 32'(i)) || ifid_pc !== 32'(i * 4) || ifid_valid !== 1'b1) begin
                nerr++;
                $display("FAIL free_run_%0d: got instr=%h pc=%h v=%b want instr=%h pc=%h v=1",
                         i, ifid_instr, ifid_pc, ifid_valid, 32'hA5A5_0000 | 32'(i), 32'(i * 4));
            end
        end
        nvec++;
        if (fetch_count !== 32'd4) begin nerr++; $display("FAIL free_run_count: got %0d want 4", fetch_count); end
    endtask

    task automatic test_stall();
        cycle(1'b0, 1'b0, 1'b1, 32'h4);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'h0);
            nvec++;
            if (pc !== 32'h8 || ifid_instr !== 32'hA5A5_0001 || fetch_count !== m_cnt) begin
                nerr++;
                $display("FAIL stall_hold_%0d: got pc=%h instr=%h cnt=%0d want pc=8 instr=a5a50001 cnt=%0d",
                         i, pc, ifid_instr, fetch_count, m_cnt);
            end
        end
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        nvec++;
        if (ifid_instr !== 32'hA5A5_0002 || ifid_pc !== 32'h8) begin
            nerr++; $display("FAIL stall_resume: got instr=%h pc=%h want a5a50002/8", ifid_instr, ifid_pc);
        end
    endtask

    task automatic test_redirect();
        cycle(1'b0, 1'b0, 1'b1, 32'h40);
        nvec++;
        if (pc !== 32'h40 || ifid_instr !== 32'h13 || ifid_valid !== 1'b0) begin
            nerr++; $display("FAIL redirect_n1: got pc=%h instr=%h v=%b want 40/13/0", pc, ifid_instr, ifid_valid);
        end
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        nvec++;
        if (ifid_instr !== 32'hA5A5_0010 || ifid_pc !== 32'h40 || ifid_pc4 !== 32'h44) begin
            nerr++; $display("FAIL redirect_n2: got instr=%h pc=%h pc4=%h want a5a50010/40/44", ifid_instr, ifid_pc, ifid_pc4);
        end
    endtask

    task automatic test_misalign_stall();
        cycle(1'b1, 1'b1, 1'b1, 32'h42);
        nvec++;
        if (pc !== 32'h40 || misalign !== 1'b1 || ifid_valid !== 1'b0 || ifid_instr !== 32'h13) begin
            nerr++; $display("FAIL misalign_set: got pc=%h mis=%b v=%b instr=%h want 40/1/0/13", pc, misalign, ifid_valid, ifid_instr);
        end
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        nvec++;
        if (misalign !== 1'b0 || ifid_instr !== 32'hA5A5_0010) begin
            nerr++; $display("FAIL misalign_clear: got mis=%b instr=%h want 0/a5a50010", misalign, ifid_instr);
        end
    endtask

    task automatic test_flush();
        logic [31:0] cnt0;
        cycle(1'b0, 1'b0, 1'b1, 32'h4);
        cnt0 = m_cnt;
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        nvec++;
        if (pc !== 32'h8 || ifid_valid !== 1'b0 || ifid_instr !== 32'h13 || fetch_count !== cnt0) begin
            nerr++; $display("FAIL flush: got pc=%h v=%b instr=%h cnt=%0d want 8/0/13/%0d", pc, ifid_valid, ifid_instr, fetch_count, cnt0);
        end
    endtask

    task automatic test_async_reset();
        cycle(1'b0, 1'b0, 1'b1, 32'h40);
        redirect = 1'b1;
        redirect_target = 32'h80;
        #3 rst = 1'b1;
        #1;
        nvec++;
        if (pc !== 32'h0 || imem_addr !== 32'h0 || ifid_valid !== 1'b0 || fetch_count !== 32'h0) begin
            nerr++; $display("FAIL async_reset: got pc=%h addr=%h v=%b cnt=%0d want 0/0/0/0", pc, imem_addr, ifid_valid, fetch_count);
        end
        @(posedge clk);
        #1;
        nvec++;
        if (pc !== 32'h0 || misalign !== 1'b0) begin
            nerr++; $display("FAIL reset_discards_redirect: got pc=%h mis=%b want 0/0", pc, misalign);
        end
        redirect = 1'b0;
        redirect_target = 32'h0;
        rst = 1'b0;
        model_reset();
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        nvec++;
        if (ifid_instr !== 32'hA5A5_0000 || pc !== 32'h4) begin
            nerr++; $display("FAIL post_reset_fetch: got instr=%h pc=%h want a5a50000/4", ifid_instr, pc);
        end
    endtask

    task automatic test_wrap();
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        nvec++;
        if (pc !== 32'h0 || ifid_pc !== 32'hFFFF_FFFC || ifid_pc4 !== 32'h0 || ifid_instr !== 32'hA5A5_FFFF) begin
            nerr++; $display("FAIL pc_wrap: got pc=%h ipc=%h ipc4=%h instr=%h want 0/fffffffc/0/a5a5ffff", pc, ifid_pc, ifid_pc4, ifid_instr);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] t;
        for (int i = 0; i < 60; i++) begin
            t = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom();
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0, t);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_redirect();
        test_misalign_stall();
        test_flush();
        test_async_reset();
        test_wrap();
        test_back_to_back();
        #2;
        nvec++;
        if (sb.size() != 0) begin nerr++; $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
